// File: rtl/lsu_bus_bridge_if.sv
// Data-bus side of the LSU bridge: req/gnt address phase plus rvalid response phase.
// The master modport is the bridge; the slave modport is the memory/interconnect.
interface lsu_bus_bridge_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/lsu_bus_bridge.sv
// Single-entry bridge from the grant-less LSU data port to a req/gnt + rvalid bus.
// Holds the core stalled while the access is in flight and replays completion as a one-cycle pulse.
module lsu_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_req_i,
  input  logic [31:0]           core_addr_i,
  input  logic                  core_we_i,
  input  logic [3:0]            core_be_i,
  input  logic [31:0]           core_wdata_i,
  output logic                  core_rvalid_o,
  output logic [31:0]           core_rdata_o,
  output logic                  core_err_o,
  output logic                  core_stall_o,
  lsu_bus_bridge_if.master      bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              stray_q, stray_d;

  logic              accept;
  logic              toHit;
  logic              busReq;

  // A stray response owed by a timed-out access blocks new requests until it drains.
  assign accept = (state_q == IDLE) && core_req_i && !stray_q;
  assign toHit  = TO_EN && (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = REQ;
      REQ: begin
        if (bus.gnt)    state_d = RESP;
        else if (toHit) state_d = DONE;
      end
      RESP: begin
        if (bus.rvalid || toHit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    core_stall_o  = 1'b0;
    core_rvalid_o = 1'b0;
    core_err_o    = 1'b0;
    busReq        = 1'b0;
    unique case (state_q)
      IDLE: core_stall_o = rst_n && (core_req_i || stray_q);
      REQ: begin
        core_stall_o = 1'b1;
        busReq       = 1'b1;
      end
      RESP: core_stall_o = 1'b1;
      DONE: begin
        core_rvalid_o = 1'b1;
        core_err_o    = err_q;
      end
      default: core_stall_o = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    stray_d = stray_q;

    if (stray_q && bus.rvalid) begin
      stray_d = 1'b0;
    end

    if (accept) begin
      addr_d  = core_addr_i & 32'hFFFF_FFFC;
      we_d    = core_we_i;
      be_d    = core_be_i;
      wdata_d = core_wdata_i;
      cnt_d   = '0;
    end

    if ((state_q == REQ) || (state_q == RESP)) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if ((state_q == REQ) && !bus.gnt && toHit) begin
      err_d   = 1'b1;
      rdata_d = '0;
    end

    // Stores leave the previous load data visible on core_rdata_o.
    if (state_q == RESP) begin
      if (bus.rvalid) begin
        if (!we_q) begin
          rdata_d = bus.rdata;
        end
        err_d = bus.err;
      end else if (toHit) begin
        err_d   = 1'b1;
        rdata_d = '0;
        stray_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      stray_q <= stray_d;
    end
  end

  assign bus.req      = busReq;
  assign bus.addr     = addr_q;
  assign bus.we       = we_q;
  assign bus.be       = be_q;
  assign bus.wdata    = wdata_q;
  assign core_rdata_o = rdata_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge: one default-timeout instance and one with TIMEOUT_CYCLES=4.
module tb_lsu_bus_bridge;

  logic        clk;
  logic        rst_n;
  logic        coreReq;
  logic        toReq;
  logic [31:0] coreAddr;
  logic        coreWe;
  logic [3:0]  coreBe;
  logic [31:0] coreWdata;

  logic        coreRvalid, coreErr, coreStall;
  logic [31:0] coreRdata;
  logic        toRvalid, toErr, toStall;
  logic [31:0] toRdata;

  int checks;
  int failures;

  lsu_bus_bridge_if busIf ();
  lsu_bus_bridge_if busTo ();

  lsu_bus_bridge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_req_i   (coreReq),
    .core_addr_i  (coreAddr),
    .core_we_i    (coreWe),
    .core_be_i    (coreBe),
    .core_wdata_i (coreWdata),
    .core_rvalid_o(coreRvalid),
    .core_rdata_o (coreRdata),
    .core_err_o   (coreErr),
    .core_stall_o (coreStall),
    .bus          (busIf.master)
  );

  lsu_bus_bridge #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dutTo (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_req_i   (toReq),
    .core_addr_i  (coreAddr),
    .core_we_i    (coreWe),
    .core_be_i    (coreBe),
    .core_wdata_i (coreWdata),
    .core_rvalid_o(toRvalid),
    .core_rdata_o (toRdata),
    .core_err_o   (toErr),
    .core_stall_o (toStall),
    .bus          (busTo.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each call advances to the next falling edge, drives one cycle of inputs, then settles.
  task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic we,
                               input logic [3:0] be, input logic [31:0] wdata,
                               input logic gnt, input logic rvalid,
                               input logic [31:0] rdata, input logic err);
    @(negedge clk);
    coreReq      = req;
    coreAddr     = addr;
    coreWe       = we;
    coreBe       = be;
    coreWdata    = wdata;
    busIf.gnt    = gnt;
    busIf.rvalid = rvalid;
    busIf.rdata  = rdata;
    busIf.err    = err;
    #1;
  endtask

  task automatic applyTimeoutStimulus(input logic req, input logic [31:0] addr, input logic gnt,
                                      input logic rvalid, input logic [31:0] rdata);
    @(negedge clk);
    toReq        = req;
    coreAddr     = addr;
    coreWe       = 1'b0;
    coreBe       = 4'hF;
    coreWdata    = 32'h0;
    busTo.gnt    = gnt;
    busTo.rvalid = rvalid;
    busTo.rdata  = rdata;
    busTo.err    = 1'b0;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before end of sequence");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    coreReq      = 1'b0;
    toReq        = 1'b0;
    coreAddr     = '0;
    coreWe       = 1'b0;
    coreBe       = '0;
    coreWdata    = '0;
    busIf.gnt    = 1'b0;
    busIf.rvalid = 1'b0;
    busIf.rdata  = '0;
    busIf.err    = 1'b0;
    busTo.gnt    = 1'b0;
    busTo.rvalid = 1'b0;
    busTo.rdata  = '0;
    busTo.err    = 1'b0;

    // Reset state
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("rst_rvalid", {31'b0, coreRvalid}, 32'd0);
    checkOutput("rst_rdata", coreRdata, 32'd0);
    checkOutput("rst_err", {31'b0, coreErr}, 32'd0);
    checkOutput("rst_stall", {31'b0, coreStall}, 32'd0);
    checkOutput("rst_busreq", {31'b0, busIf.req}, 32'd0);
    checkOutput("rst_busaddr", busIf.addr, 32'd0);
    rst_n = 1'b1;

    // Minimum-latency load
    applyStimulus(1'b1, 32'h1000_0004, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("ld_c0_stall", {31'b0, coreStall}, 32'd1);
    checkOutput("ld_c0_busreq", {31'b0, busIf.req}, 32'd0);
    applyStimulus(1'b1, 32'h1000_0004, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("ld_c1_busreq", {31'b0, busIf.req}, 32'd1);
    checkOutput("ld_c1_addr", busIf.addr, 32'h1000_0004);
    checkOutput("ld_c1_we", {31'b0, busIf.we}, 32'd0);
    checkOutput("ld_c1_stall", {31'b0, coreStall}, 32'd1);
    applyStimulus(1'b1, 32'h1000_0004, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    checkOutput("ld_c2_stall", {31'b0, coreStall}, 32'd1);
    checkOutput("ld_c2_busreq", {31'b0, busIf.req}, 32'd0);
    checkOutput("ld_c2_rvalid", {31'b0, coreRvalid}, 32'd0);
    applyStimulus(1'b1, 32'h1000_0004, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("ld_c3_rvalid", {31'b0, coreRvalid}, 32'd1);
    checkOutput("ld_c3_rdata", coreRdata, 32'hDEAD_BEEF);
    checkOutput("ld_c3_err", {31'b0, coreErr}, 32'd0);
    checkOutput("ld_c3_stall", {31'b0, coreStall}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("ld_c4_rvalid", {31'b0, coreRvalid}, 32'd0);
    checkOutput("ld_c4_rdata_hold", coreRdata, 32'hDEAD_BEEF);

    // Misaligned store with grant delayed five cycles
    applyStimulus(1'b1, 32'h0000_2003, 1'b1, 4'b1000, 32'h1100_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("st_c0_stall", {31'b0, coreStall}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h0000_2003, 1'b1, 4'b1000, 32'h1100_0000, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("st_wait_busreq", {31'b0, busIf.req}, 32'd1);
      checkOutput("st_wait_addr", busIf.addr, 32'h0000_2000);
      checkOutput("st_wait_be", {28'b0, busIf.be}, 32'h8);
      checkOutput("st_wait_wdata", busIf.wdata, 32'h1100_0000);
      checkOutput("st_wait_we", {31'b0, busIf.we}, 32'd1);
    end
    applyStimulus(1'b1, 32'h0000_2003, 1'b1, 4'b1000, 32'h1100_0000, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("st_gnt_busreq", {31'b0, busIf.req}, 32'd1);
    applyStimulus(1'b1, 32'h0000_2003, 1'b1, 4'b1000, 32'h1100_0000, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
    checkOutput("st_postgnt_busreq", {31'b0, busIf.req}, 32'd0);
    checkOutput("st_resp_stall", {31'b0, coreStall}, 32'd1);
    applyStimulus(1'b1, 32'h0000_2003, 1'b1, 4'b1000, 32'h1100_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("st_done_rvalid", {31'b0, coreRvalid}, 32'd1);
    checkOutput("st_done_rdata", coreRdata, 32'hDEAD_BEEF);
    checkOutput("st_done_err", {31'b0, coreErr}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Load completing with a bus error
    applyStimulus(1'b1, 32'h0000_3000, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h0000_3000, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h0000_3000, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0000_0055, 1'b1);
    applyStimulus(1'b1, 32'h0000_3000, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("err_rvalid", {31'b0, coreRvalid}, 32'd1);
    checkOutput("err_err", {31'b0, coreErr}, 32'd1);
    checkOutput("err_rdata", coreRdata, 32'h0000_0055);
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("err_after_err", {31'b0, coreErr}, 32'd0);

    // Back-to-back halves of a misaligned load
    applyStimulus(1'b1, 32'h0000_4001, 1'b0, 4'hE, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h0000_4001, 1'b0, 4'hE, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("pair1_addr", busIf.addr, 32'h0000_4000);
    applyStimulus(1'b1, 32'h0000_4001, 1'b0, 4'hE, 32'h0, 1'b0, 1'b1, 32'hA1A1_A1A1, 1'b0);
    applyStimulus(1'b1, 32'h0000_4001, 1'b0, 4'hE, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("pair1_rvalid", {31'b0, coreRvalid}, 32'd1);
    checkOutput("pair1_rdata", coreRdata, 32'hA1A1_A1A1);
    applyStimulus(1'b1, 32'h0000_4005, 1'b0, 4'h1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("pair2_idle_rvalid", {31'b0, coreRvalid}, 32'd0);
    checkOutput("pair2_idle_stall", {31'b0, coreStall}, 32'd1);
    applyStimulus(1'b1, 32'h0000_4005, 1'b0, 4'h1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("pair2_busreq", {31'b0, busIf.req}, 32'd1);
    checkOutput("pair2_addr", busIf.addr, 32'h0000_4004);
    checkOutput("pair2_be", {28'b0, busIf.be}, 32'h1);
    applyStimulus(1'b1, 32'h0000_4005, 1'b0, 4'h1, 32'h0, 1'b0, 1'b1, 32'hB2B2_B2B2, 1'b0);
    applyStimulus(1'b1, 32'h0000_4005, 1'b0, 4'h1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("pair2_rvalid", {31'b0, coreRvalid}, 32'd1);
    checkOutput("pair2_rdata", coreRdata, 32'hB2B2_B2B2);
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Asynchronous reset while the request is on the bus
    applyStimulus(1'b1, 32'h0000_5000, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h0000_5000, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("arst_pre_busreq", {31'b0, busIf.req}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busreq", {31'b0, busIf.req}, 32'd0);
    checkOutput("arst_stall", {31'b0, coreStall}, 32'd0);
    checkOutput("arst_rdata", coreRdata, 32'd0);
    checkOutput("arst_busaddr", busIf.addr, 32'd0);
    applyStimulus(1'b1, 32'h0000_5008, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("arst_held_stall", {31'b0, coreStall}, 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h0000_5008, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("post_rst_busreq", {31'b0, busIf.req}, 32'd1);
    checkOutput("post_rst_addr", busIf.addr, 32'h0000_5008);
    applyStimulus(1'b1, 32'h0000_5008, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0000_600D, 1'b0);
    applyStimulus(1'b1, 32'h0000_5008, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("post_rst_rvalid", {31'b0, coreRvalid}, 32'd1);
    checkOutput("post_rst_rdata", coreRdata, 32'h0000_600D);
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // TIMEOUT_CYCLES=4: a good load first so the timeout clearing rdata is visible
    applyTimeoutStimulus(1'b1, 32'h0000_6000, 1'b0, 1'b0, 32'h0);
    applyTimeoutStimulus(1'b1, 32'h0000_6000, 1'b1, 1'b0, 32'h0);
    applyTimeoutStimulus(1'b1, 32'h0000_6000, 1'b0, 1'b1, 32'h1234_5678);
    applyTimeoutStimulus(1'b1, 32'h0000_6000, 1'b0, 1'b0, 32'h0);
    checkOutput("to_ok_rvalid", {31'b0, toRvalid}, 32'd1);
    checkOutput("to_ok_rdata", toRdata, 32'h1234_5678);
    applyTimeoutStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // No grant: four request cycles then an error completion
    applyTimeoutStimulus(1'b1, 32'h0000_6100, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyTimeoutStimulus(1'b1, 32'h0000_6100, 1'b0, 1'b0, 32'h0);
      checkOutput("to_gnt_busreq", {31'b0, busTo.req}, 32'd1);
      checkOutput("to_gnt_rvalid", {31'b0, toRvalid}, 32'd0);
    end
    applyTimeoutStimulus(1'b1, 32'h0000_6100, 1'b0, 1'b0, 32'h0);
    checkOutput("to_gnt_done_rvalid", {31'b0, toRvalid}, 32'd1);
    checkOutput("to_gnt_done_err", {31'b0, toErr}, 32'd1);
    checkOutput("to_gnt_done_rdata", toRdata, 32'd0);
    checkOutput("to_gnt_done_busreq", {31'b0, busTo.req}, 32'd0);
    applyTimeoutStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("to_gnt_idle_err", {31'b0, toErr}, 32'd0);

    // Granted but no response: timeout, then the late response is swallowed
    applyTimeoutStimulus(1'b1, 32'h0000_6200, 1'b0, 1'b0, 32'h0);
    applyTimeoutStimulus(1'b1, 32'h0000_6200, 1'b1, 1'b0, 32'h0);
    checkOutput("to_rsp_busreq", {31'b0, busTo.req}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyTimeoutStimulus(1'b1, 32'h0000_6200, 1'b0, 1'b0, 32'h0);
      checkOutput("to_rsp_wait_stall", {31'b0, toStall}, 32'd1);
      checkOutput("to_rsp_wait_busreq", {31'b0, busTo.req}, 32'd0);
    end
    applyTimeoutStimulus(1'b1, 32'h0000_6200, 1'b0, 1'b0, 32'h0);
    checkOutput("to_rsp_done_rvalid", {31'b0, toRvalid}, 32'd1);
    checkOutput("to_rsp_done_err", {31'b0, toErr}, 32'd1);
    applyTimeoutStimulus(1'b1, 32'h0000_6300, 1'b0, 1'b0, 32'h0);
    checkOutput("stray_c6_stall", {31'b0, toStall}, 32'd1);
    applyTimeoutStimulus(1'b1, 32'h0000_6300, 1'b0, 1'b0, 32'h0);
    checkOutput("stray_c7_busreq", {31'b0, busTo.req}, 32'd0);
    checkOutput("stray_c7_stall", {31'b0, toStall}, 32'd1);
    applyTimeoutStimulus(1'b1, 32'h0000_6300, 1'b0, 1'b1, 32'h0000_0077);
    checkOutput("stray_late_rvalid", {31'b0, toRvalid}, 32'd0);
    checkOutput("stray_late_busreq", {31'b0, busTo.req}, 32'd0);
    applyTimeoutStimulus(1'b1, 32'h0000_6300, 1'b0, 1'b0, 32'h0);
    checkOutput("stray_drained_rvalid", {31'b0, toRvalid}, 32'd0);
    checkOutput("stray_drained_rdata", toRdata, 32'd0);
    applyTimeoutStimulus(1'b1, 32'h0000_6300, 1'b1, 1'b0, 32'h0);
    checkOutput("recover_busreq", {31'b0, busTo.req}, 32'd1);
    checkOutput("recover_addr", busTo.addr, 32'h0000_6300);
    applyTimeoutStimulus(1'b1, 32'h0000_6300, 1'b0, 1'b1, 32'h0000_0099);
    applyTimeoutStimulus(1'b1, 32'h0000_6300, 1'b0, 1'b0, 32'h0);
    checkOutput("recover_rvalid", {31'b0, toRvalid}, 32'd1);
    checkOutput("recover_rdata", toRdata, 32'h0000_0099);
    checkOutput("recover_err", {31'b0, toErr}, 32'd0);
    applyTimeoutStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
